// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator request issuer.
package calc_pkg;

    localparam int NUM_TAGS = 4;

    typedef logic [1:0]  tag_t;
    typedef logic [31:0] data_t;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_OVF  = 2'd2,
        RESP_INV  = 2'd3
    } resp_e;

endpackage

// File: rtl/calc_tag_pool.sv
// Tag pool: busy bitmap, lowest-free allocator, per-tag command store and
// per-tag age counters that raise a one-cycle timeout pulse.
module calc_tag_pool
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic                alloc_i,
    input  logic [3:0]          alloc_cmd_i,
    input  logic                free_i,
    input  tag_t                free_tag_i,
    input  tag_t                rd_tag_i,
    output tag_t                grant_tag_o,
    output logic                any_free_o,
    output logic [NUM_TAGS-1:0] busy_o,
    output logic [3:0]          rd_cmd_o,
    output logic [NUM_TAGS-1:0] tmo_pulse_o
);

    localparam int AGE_W = $clog2(TIMEOUT + 1);

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [3:0]          cmd_q [NUM_TAGS];
    logic [3:0]          cmd_d [NUM_TAGS];
    logic [AGE_W-1:0]    age_q [NUM_TAGS];
    logic [AGE_W-1:0]    age_d [NUM_TAGS];

    assign any_free_o = ~&busy_q;
    assign busy_o     = busy_q;
    assign rd_cmd_o   = cmd_q[rd_tag_i];

    // Lowest-index free tag; scanning downward leaves the lowest one last.
    always_comb begin
        grant_tag_o = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) grant_tag_o = tag_t'(i);
        end
    end

    // Timeout fires when the age reaches TIMEOUT; a same-cycle response wins.
    always_comb begin
        tmo_pulse_o = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            tmo_pulse_o[i] = busy_q[i] && (age_q[i] == AGE_W'(TIMEOUT))
                             && !(free_i && (free_tag_i == tag_t'(i)));
        end
    end

    // Next-state for bitmap, stored commands and age counters.
    always_comb begin
        busy_d = busy_q;
        cmd_d  = cmd_q;
        age_d  = age_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (alloc_i && (grant_tag_o == tag_t'(i))) begin
                busy_d[i] = 1'b1;
                cmd_d[i]  = alloc_cmd_i;
                age_d[i]  = '0;
            end else if (busy_q[i]) begin
                if ((free_i && (free_tag_i == tag_t'(i))) || tmo_pulse_o[i]) begin
                    busy_d[i] = 1'b0;
                end else begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Pool state registers.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                cmd_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cmd_q  <= cmd_d;
            age_q  <= age_d;
        end
    end

endmodule

// File: rtl/calc_req_issuer.sv
// Request issuer: accepts whole operations, serialises them into the
// two-cycle calculator request, pairs responses with their command and
// keeps sticky timeout / spurious-response flags.
//
// state | meaning
// IDLE  | ready for a new operation if a tag is free
// OP2   | second request beat (operand b) on the calculator port
module calc_req_issuer
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [3:0]  reqcmd,
    output logic [1:0]  reqtag,
    output logic [31:0] reqdata,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    input  logic [1:0]  out_tag,
    output logic        cpl_valid,
    output logic [3:0]  cpl_cmd,
    output logic [1:0]  cpl_tag,
    output logic [1:0]  cpl_resp,
    output logic [31:0] cpl_data,
    output logic        tmo_err,
    output logic [3:0]  tmo_mask,
    output logic        spur_err
);

    typedef enum logic {ST_IDLE, ST_OP2} state_e;

    state_e              state_q, state_d;
    logic                issue_q, issue_d;
    tag_t                tag_q, tag_d;
    data_t               b_q, b_d;
    logic [3:0]          reqcmd_q, reqcmd_d;
    tag_t                reqtag_q, reqtag_d;
    data_t               reqdata_q, reqdata_d;
    logic                cpl_valid_q, cpl_valid_d;
    logic [3:0]          cpl_cmd_q, cpl_cmd_d;
    tag_t                cpl_tag_q, cpl_tag_d;
    logic [1:0]          cpl_resp_q, cpl_resp_d;
    data_t               cpl_data_q, cpl_data_d;
    logic                tmo_err_q, tmo_err_d;
    logic [3:0]          tmo_mask_q, tmo_mask_d;
    logic                spur_q, spur_d;

    logic                alloc, rsp_hit, rsp_any;
    tag_t                grant_tag;
    logic                any_free;
    logic [NUM_TAGS-1:0] busy;
    logic [3:0]          rd_cmd;
    logic [NUM_TAGS-1:0] tmo_pulse;

    calc_tag_pool #(.TIMEOUT(TIMEOUT)) u_pool (
        .c_clk       (c_clk),
        .reset       (reset),
        .alloc_i     (alloc),
        .alloc_cmd_i (op_cmd),
        .free_i      (rsp_hit),
        .free_tag_i  (out_tag),
        .rd_tag_i    (out_tag),
        .grant_tag_o (grant_tag),
        .any_free_o  (any_free),
        .busy_o      (busy),
        .rd_cmd_o    (rd_cmd),
        .tmo_pulse_o (tmo_pulse)
    );

    assign rsp_any = (out_resp != RESP_NONE);
    assign rsp_hit = rsp_any && busy[out_tag];

    // FSM next state, request beats, completions and sticky flags.
    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        tag_d       = tag_q;
        b_d         = b_q;
        reqcmd_d    = '0;
        reqtag_d    = '0;
        reqdata_d   = '0;
        alloc       = 1'b0;
        op_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                op_ready = any_free && !reset;
                if (op_valid && op_ready) begin
                    state_d = ST_OP2;
                    issue_d = (op_cmd != CMD_NOP);
                    tag_d   = grant_tag;
                    b_d     = op_b;
                    // A no-op is swallowed here: no tag and no request beat.
                    if (op_cmd != CMD_NOP) begin
                        alloc     = 1'b1;
                        reqcmd_d  = op_cmd;
                        reqtag_d  = grant_tag;
                        reqdata_d = op_a;
                    end
                end
            end
            ST_OP2: begin
                state_d = ST_IDLE;
                if (issue_q) begin
                    reqtag_d  = tag_q;
                    reqdata_d = b_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cpl_valid_d = rsp_hit;
        cpl_cmd_d   = rsp_hit ? rd_cmd : '0;
        cpl_tag_d   = rsp_hit ? out_tag : '0;
        cpl_resp_d  = rsp_hit ? out_resp : '0;
        cpl_data_d  = rsp_hit ? out_data : '0;

        spur_d    = spur_q | (rsp_any && !busy[out_tag]);
        tmo_err_d = tmo_err_q | (|tmo_pulse);
        // Mask is numbered from the MSB: tag 0 is bit 3, tag 3 is bit 0.
        tmo_mask_d = tmo_mask_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (tmo_pulse[i]) tmo_mask_d[NUM_TAGS-1-i] = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            issue_q     <= 1'b0;
            tag_q       <= '0;
            b_q         <= '0;
            reqcmd_q    <= '0;
            reqtag_q    <= '0;
            reqdata_q   <= '0;
            cpl_valid_q <= 1'b0;
            cpl_cmd_q   <= '0;
            cpl_tag_q   <= '0;
            cpl_resp_q  <= '0;
            cpl_data_q  <= '0;
            tmo_err_q   <= 1'b0;
            tmo_mask_q  <= '0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            tag_q       <= tag_d;
            b_q         <= b_d;
            reqcmd_q    <= reqcmd_d;
            reqtag_q    <= reqtag_d;
            reqdata_q   <= reqdata_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_cmd_q   <= cpl_cmd_d;
            cpl_tag_q   <= cpl_tag_d;
            cpl_resp_q  <= cpl_resp_d;
            cpl_data_q  <= cpl_data_d;
            tmo_err_q   <= tmo_err_d;
            tmo_mask_q  <= tmo_mask_d;
            spur_q      <= spur_d;
        end
    end

    assign reqcmd    = reqcmd_q;
    assign reqtag    = reqtag_q;
    assign reqdata   = reqdata_q;
    assign cpl_valid = cpl_valid_q;
    assign cpl_cmd   = cpl_cmd_q;
    assign cpl_tag   = cpl_tag_q;
    assign cpl_resp  = cpl_resp_q;
    assign cpl_data  = cpl_data_q;
    assign tmo_err   = tmo_err_q;
    assign tmo_mask  = tmo_mask_q;
    assign spur_err  = spur_q;

endmodule

// File: tb/tb_calc_req_issuer.sv
// Directed bench for calc_req_issuer with hand-computed expectations.
module tb_calc_req_issuer;

    localparam int TMO = 32;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_cmd = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [3:0]  reqcmd;
    logic [1:0]  reqtag;
    logic [31:0] reqdata;
    logic [1:0]  out_resp = '0;
    logic [31:0] out_data = '0;
    logic [1:0]  out_tag = '0;
    logic        cpl_valid;
    logic [3:0]  cpl_cmd;
    logic [1:0]  cpl_tag;
    logic [1:0]  cpl_resp;
    logic [31:0] cpl_data;
    logic        tmo_err;
    logic [3:0]  tmo_mask;
    logic        spur_err;

    int n_chk  = 0;
    int n_pass = 0;

    calc_req_issuer #(.TIMEOUT(TMO)) dut (
        .c_clk     (c_clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_cmd    (op_cmd),
        .op_a      (op_a),
        .op_b      (op_b),
        .reqcmd    (reqcmd),
        .reqtag    (reqtag),
        .reqdata   (reqdata),
        .out_resp  (out_resp),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .cpl_valid (cpl_valid),
        .cpl_cmd   (cpl_cmd),
        .cpl_tag   (cpl_tag),
        .cpl_resp  (cpl_resp),
        .cpl_data  (cpl_data),
        .tmo_err   (tmo_err),
        .tmo_mask  (tmo_mask),
        .spur_err  (spur_err)
    );

    always #5 c_clk = ~c_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // Offer one operation for a single cycle; returns in the cycle after.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_cmd   = c;
        op_a     = a;
        op_b     = b;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic respond(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
        out_resp = r;
        out_tag  = t;
        out_data = d;
        tick();
        out_resp = '0;
    endtask

    logic [3:0] cmds [4];

    initial begin
        cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd5; cmds[3] = 4'd6;

        // Reset values
        tick();
        tick();
        chk("rst_op_ready", op_ready, 0);
        chk("rst_reqcmd", reqcmd, 0);
        chk("rst_reqdata", reqdata, 0);
        chk("rst_cpl_valid", cpl_valid, 0);
        chk("rst_tmo_err", tmo_err, 0);
        chk("rst_tmo_mask", tmo_mask, 0);
        chk("rst_spur", spur_err, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_op_ready", op_ready, 1);

        // Single add with response
        issue(4'd1, 32'd5, 32'd7);
        chk("add_b1_cmd", reqcmd, 1);
        chk("add_b1_tag", reqtag, 0);
        chk("add_b1_data", reqdata, 5);
        chk("add_op2_ready", op_ready, 0);
        tick();
        chk("add_b2_cmd", reqcmd, 0);
        chk("add_b2_tag", reqtag, 0);
        chk("add_b2_data", reqdata, 7);
        chk("add_b2_ready", op_ready, 1);
        tick();
        chk("add_b3_data", reqdata, 0);
        respond(2'd1, 2'd0, 32'd12);
        chk("add_cpl_valid", cpl_valid, 1);
        chk("add_cpl_cmd", cpl_cmd, 1);
        chk("add_cpl_tag", cpl_tag, 0);
        chk("add_cpl_resp", cpl_resp, 1);
        chk("add_cpl_data", cpl_data, 12);
        tick();
        chk("add_cpl_one_cycle", cpl_valid, 0);

        // Four back-to-back ops fill the pool
        for (int k = 0; k < 4; k++) begin
            issue(cmds[k], 32'(k + 16), 32'(k + 32));
            chk("fill_tag", reqtag, k);
            chk("fill_cmd", reqcmd, cmds[k]);
            tick();
        end
        chk("full_ready", op_ready, 0);
        // Fifth op waits; a response on tag 2 frees it for reuse
        op_valid = 1'b1;
        op_cmd   = 4'd7;
        op_a     = 32'd99;
        op_b     = 32'd98;
        out_resp = 2'd1;
        out_tag  = 2'd2;
        out_data = 32'h55;
        tick();
        out_resp = '0;
        chk("full_no_issue", reqcmd, 0);
        chk("reuse_cpl_cmd", cpl_cmd, 5);
        chk("reuse_cpl_tag", cpl_tag, 2);
        chk("reuse_ready", op_ready, 1);
        tick();
        op_valid = 1'b0;
        chk("reuse_tag", reqtag, 2);
        chk("reuse_cmd", reqcmd, 7);
        chk("reuse_data", reqdata, 99);
        tick();
        chk("reuse_b2_data", reqdata, 98);

        // Out-of-order responses
        respond(2'd2, 2'd3, 32'hAA);
        chk("ooo3_valid", cpl_valid, 1);
        chk("ooo3_cmd", cpl_cmd, 6);
        chk("ooo3_resp", cpl_resp, 2);
        chk("ooo3_data", cpl_data, 32'hAA);
        respond(2'd1, 2'd0, 32'h10);
        chk("ooo0_cmd", cpl_cmd, 1);
        chk("ooo0_tag", cpl_tag, 0);
        respond(2'd3, 2'd2, 32'h0);
        chk("ooo2_cmd", cpl_cmd, 7);
        chk("ooo2_resp", cpl_resp, 3);
        respond(2'd1, 2'd1, 32'h1);
        chk("ooo1_cmd", cpl_cmd, 2);
        chk("ooo_no_spur", spur_err, 0);

        // Timeout on tag 1 while tag 0 completes
        issue(4'd1, 32'd1, 32'd1);
        tick();
        issue(4'd2, 32'd3, 32'd4);
        chk("tmo_alloc_tag", reqtag, 1);
        respond(2'd1, 2'd0, 32'd2);
        chk("tmo_t0_cpl", cpl_tag, 0);
        repeat (TMO - 1) tick();
        chk("tmo_not_early", tmo_err, 0);
        tick();
        chk("tmo_err", tmo_err, 1);
        chk("tmo_mask", tmo_mask, 4'b0100);
        chk("tmo_no_cpl", cpl_valid, 0);
        respond(2'd1, 2'd1, 32'd7);
        chk("late_spur", spur_err, 1);
        chk("late_no_cpl", cpl_valid, 0);
        chk("tmo_sticky", tmo_err, 1);

        // Reset in OP2
        issue(4'd1, 32'h11, 32'h22);
        tick();
        issue(4'd2, 32'h33, 32'h44);
        chk("mid_tag", reqtag, 1);
        chk("mid_data", reqdata, 32'h33);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_data", reqdata, 0);
        chk("mid_rst_tag", reqtag, 0);
        chk("mid_rst_ready", op_ready, 0);
        chk("mid_rst_spur", spur_err, 0);
        chk("mid_rst_mask", tmo_mask, 0);
        tick();
        reset = 1'b0;
        issue(4'd5, 32'h3, 32'h1);
        chk("after_rst_tag", reqtag, 0);
        chk("after_rst_cmd", reqcmd, 5);
        tick();

        // No-op consumes nothing
        issue(4'd0, 32'h77, 32'h88);
        chk("nop_cmd", reqcmd, 0);
        chk("nop_data", reqdata, 0);
        tick();
        chk("nop_b2_data", reqdata, 0);
        chk("nop_no_cpl", cpl_valid, 0);
        issue(4'd6, 32'h9, 32'h1);
        chk("nop_next_tag", reqtag, 1);
        chk("nop_next_cmd", reqcmd, 6);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/calc_req_issuer.md
# calc_req_issuer

Per-port request issuer that sits directly upstream of one calculator port. Accepts whole operations (command plus two operands) over a valid/ready handshake and serialises each into the calculator's two-cycle request protocol. Allocates one of four tags per request and tracks outstanding requests. Pairs each calculator response with its original command on a completion stream, and flags timeouts and spurious responses.

## Interface
- TIMEOUT, 64, cycles a tag may stay outstanding before it is declared lost; minimum 4.
- c_clk  in  1  sole clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- op_valid  in  1  upstream offers an operation.
- op_ready  out  1  issuer accepts the operation this cycle.
- op_cmd  in  4  command.
- op_a  in  32  operand 1.
- op_b  in  32  operand 2.
- reqcmd  out  4  calculator request command.
- reqtag  out  2  calculator request tag.
- reqdata  out  32  calculator request data.
- out_resp  in  2  calculator response code; 0 = none.
- out_data  in  32  calculator result.
- out_tag  in  2  calculator response tag.
- cpl_valid  out  1  completion strobe; one cycle, no backpressure.
- cpl_cmd  out  4  command of the completed request.
- cpl_tag  out  2  tag of the completed request.
- cpl_resp  out  2  response code.
- cpl_data  out  32  result.
- tmo_err  out  1  sticky: at least one tag timed out.
- tmo_mask  out  4  sticky: per-tag timeout flags.
- spur_err  out  1  sticky: a response arrived for a tag that was not outstanding.

## Operation
- Commands: 0 no-op, 1 add, 2 sub, 5 shift-left, 6 shift-right. Other codes are forwarded unchanged; the calculator answers them with resp 3.
- Responses: 1 success, 2 overflow/underflow, 3 invalid command.
- FSM states:
  - IDLE: op_ready = (any tag free) and op_valid-independent. On op_valid && op_ready, go to OP2.
  - OP2: op_ready = 0. Return to IDLE unconditionally after one cycle.
- Tag allocation: the lowest-index free tag. The tag is marked busy, and op_cmd is stored per tag.
- op_cmd = 0 never reaches the calculator. It is accepted, no tag is allocated, and no completion is produced.
- Response handling: out_resp != 0 with out_tag busy produces a completion and frees the tag. With out_tag not busy, spur_err is set and nothing is forwarded.
- Age counter per busy tag: cleared at allocation, incremented each cycle while busy.
- Timeout: when a counter reaches TIMEOUT, the tag is freed and tmo_mask[tag] and tmo_err are set. A later response on that tag counts as spurious unless the tag has been reallocated.
- Sticky flags clear only on reset.

## Timing
- Reset values: op_ready 0 while reset is asserted, 1 in the first cycle after. reqcmd, reqtag, reqdata, all cpl_* outputs, tmo_err, tmo_mask and spur_err are all 0. All tags are free and the FSM is in IDLE.
- All calculator-facing and completion outputs are registered.
- Accept in cycle T:
  - T+1: reqcmd = op_cmd, reqtag = tag, reqdata = op_a.
  - T+2: reqcmd = 0, reqtag = tag, reqdata = op_b.
  - T+3: reqdata = 0 unless a new operation drives it.
- Earliest next accept is T+2, so the issue rate is one operation per 2 cycles.
- A response sampled in cycle R gives cpl_valid at R+1. The tag becomes free for allocation in cycle R+1.
- A response and an allocation in the same cycle touch different tags by construction. A freed tag is not visible to allocation until the next cycle.
- A response and a timeout for the same tag in the same cycle: the response wins. A completion is produced and no timeout is flagged.
- Four tags busy: op_ready = 0 until a response or timeout frees one.
- Reset mid-operation (including in OP2): the request is dropped, outstanding tags are abandoned, and outputs return to reset values immediately.

## Structure
- Package calc_pkg holds:
  - cmd_e (4-bit command enum)
  - resp_e (2-bit response enum)
  - tag_t (2-bit)
  - data_t (32-bit)
  - constant NUM_TAGS = 4
- Sub-module calc_tag_pool holds:
  - busy bitmap and lowest-index allocator
  - per-tag stored command
  - per-tag age counters with timeout detection
  - interface: alloc/free strobes, granted tag, any_free, timeout pulse mask.
- The top level holds the FSM, the output registers and the sticky flags.

## Test plan
- Reset, then accept add(op_a=5, op_b=7) at T: T+1 shows reqcmd=1, reqtag=0, reqdata=5; T+2 shows reqcmd=0, reqdata=7. Respond resp=1, tag=0, data=12 at R: cpl_valid=1, cpl_cmd=1, cpl_data=12 at R+1.
- Five back-to-back operations with no responses: tags 0, 1, 2, 3 are issued 2 cycles apart, then op_ready=0. A response on tag 2 makes the next accept reuse tag 2.
- Responses out of order (tag 3, then tag 0): completions carry the correct stored cmd for each tag.
- No response for TIMEOUT cycles on tag 1: tmo_mask=4'b0100 (bit 1 set in big-endian order) and tmo_err=1. A late response on tag 1 sets spur_err with no cpl_valid.
- Reset asserted in OP2: the outputs zero immediately. After release, the first accept uses tag 0.
- Accept op_cmd=0: no calculator activity, no completion, no tag consumed.
